// File: rtl/router_input_buffer.sv
// Mesh router input-buffer bank: NUM_PORTS independent FWFT FIFOs
// with occupancy, almost-full, sticky error flags and per-port flush.
module router_input_buffer #(
  parameter int NUM_PORTS    = 5,
  parameter int DEPTH        = 8,
  parameter int DATASIZE     = 40,
  parameter int AFULL_THRESH = DEPTH - 2,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*DATASIZE-1:0] data_in,
  input  logic [NUM_PORTS-1:0]          valid_in,
  output logic [NUM_PORTS-1:0]          full_out,
  output logic [NUM_PORTS-1:0]          afull_out,
  output logic [NUM_PORTS*DATASIZE-1:0] data_out,
  output logic [NUM_PORTS-1:0]          valid_out,
  input  logic [NUM_PORTS-1:0]          ready_in,
  output logic [NUM_PORTS*CW-1:0]       count_out,
  input  logic [NUM_PORTS-1:0]          flush,
  input  logic                          err_clr,
  output logic [NUM_PORTS-1:0]          ovf_err,
  output logic [NUM_PORTS-1:0]          udf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AFULL_THRESH);

  logic [NUM_PORTS-1:0] ovf_set;
  logic [NUM_PORTS-1:0] udf_set;

  assign ovf_set = valid_in & full_out;
  assign udf_set = ready_in & ~valid_out;

  // Sticky error flags; a new set outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= '0;
      udf_err <= '0;
    end else begin
      ovf_err <= (err_clr ? '0 : ovf_err) | ovf_set;
      udf_err <= (err_clr ? '0 : udf_err) | udf_set;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [DATASIZE-1:0] mem [DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic [CW-1:0]       cnt;
    logic                we;
    logic                re;

    assign we = valid_in[p] & ~full_out[p];
    assign re = ready_in[p] & valid_out[p];

    // Pointer and occupancy tracking; flush empties the port
    always_ff @(posedge clk) begin
      if (rst || flush[p]) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (we) wptr <= wptr + AW'(1);
        if (re) rptr <= rptr + AW'(1);
        case ({we, re})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    // Flit storage; not reset, writes suppressed by flush or reset
    always_ff @(posedge clk) begin
      if (!rst && !flush[p] && we)
        mem[wptr] <= data_in[p*DATASIZE +: DATASIZE];
    end

    assign full_out[p]  = (cnt == FULL_C);
    assign afull_out[p] = (cnt >= AF_C);
    assign valid_out[p] = (cnt != '0);
    assign count_out[p*CW +: CW] = cnt;
    assign data_out[p*DATASIZE +: DATASIZE] =
      valid_out[p] ? mem[rptr] : '0;
  end

endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: directed steps then random traffic,
// all compared against a queue-based reference model.
module tb_router_input_buffer;

  localparam int NP    = 5;
  localparam int DEPTH = 8;
  localparam int DW    = 40;
  localparam int AFT   = DEPTH - 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*DW-1:0] data_in;
  logic [NP-1:0]    valid_in;
  logic [NP-1:0]    full_out;
  logic [NP-1:0]    afull_out;
  logic [NP*DW-1:0] data_out;
  logic [NP-1:0]    valid_out;
  logic [NP-1:0]    ready_in;
  logic [NP*CW-1:0] count_out;
  logic [NP-1:0]    flush;
  logic             err_clr;
  logic [NP-1:0]    ovf_err;
  logic [NP-1:0]    udf_err;

  router_input_buffer #(
    .NUM_PORTS(NP),
    .DEPTH(DEPTH),
    .DATASIZE(DW),
    .AFULL_THRESH(AFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .valid_in(valid_in),
    .full_out(full_out),
    .afull_out(afull_out),
    .data_out(data_out),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .count_out(count_out),
    .flush(flush),
    .err_clr(err_clr),
    .ovf_err(ovf_err),
    .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q [NP][$];
  bit [NP-1:0]   m_ovf;
  bit [NP-1:0]   m_udf;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int p,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s port %0d: observed %h expected %h",
             tag, p, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit [NP-1:0] os;
    bit [NP-1:0] us;
    bit          full;
    bit          emp;
    os = '0;
    us = '0;
    if (rst) begin
      for (int p = 0; p < NP; p++) q[p].delete();
      m_ovf = '0;
      m_udf = '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        full  = (q[p].size() == DEPTH);
        emp   = (q[p].size() == 0);
        os[p] = valid_in[p] && full;
        us[p] = ready_in[p] && emp;
        if (flush[p]) begin
          q[p].delete();
        end else begin
          if (ready_in[p] && !emp) void'(q[p].pop_front());
          if (valid_in[p] && !full)
            q[p].push_back(data_in[p*DW +: DW]);
        end
      end
      m_ovf = (err_clr ? '0 : m_ovf) | os;
      m_udf = (err_clr ? '0 : m_udf) | us;
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NP; p++) begin
      int n;
      logic [DW-1:0] hd;
      n  = q[p].size();
      hd = (n != 0) ? q[p][0] : '0;
      check("count", p, count_out[p*CW +: CW], n);
      check("valid", p, valid_out[p], n != 0);
      check("full", p, full_out[p], n == DEPTH);
      check("afull", p, afull_out[p], n >= AFT);
      check("data", p, data_out[p*DW +: DW], hd);
      check("ovf", p, ovf_err[p], m_ovf[p]);
      check("udf", p, udf_err[p], m_udf[p]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    rst      = 1'b0;
    data_in  = '0;
    valid_in = '0;
    ready_in = '0;
    flush    = '0;
    err_clr  = 1'b0;
  endtask

  task automatic put(input int p, input logic [DW-1:0] v);
    data_in[p*DW +: DW] = v;
    valid_in[p] = 1'b1;
  endtask

  initial begin
    logic [63:0] r;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_counts", 0, count_out, 0);
    check("rst_valid", 0, valid_out, 0);

    // fill port 0
    for (int i = 1; i <= 8; i++) begin
      put(0, DW'(i));
      step();
      if (i == 5) check("afull_at5", 0, afull_out[0], 0);
      if (i == 6) check("afull_at6", 0, afull_out[0], 1);
    end
    check("full_at8", 0, full_out[0], 1);
    check("cnt_at8", 0, count_out[0 +: CW], 8);

    // drain port 0 in order
    idle();
    ready_in[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("pop_seq", 0, data_out[0 +: DW], i);
      step();
    end
    ready_in[0] = 1'b0;
    check("drain_valid", 0, valid_out[0], 0);
    check("drain_data", 0, data_out[0 +: DW], 0);

    // steady read+write at count 4
    for (int i = 0; i < 4; i++) begin
      put(0, DW'('h10 + i));
      step();
    end
    for (int i = 0; i < 20; i++) begin
      put(0, DW'('h20 + i));
      ready_in[0] = 1'b1;
      step();
    end
    idle();
    check("rw_cnt4", 0, count_out[0 +: CW], 4);
    check("rw_head", 0, data_out[0 +: DW], 'h30);

    // read+write at full: write dropped
    for (int i = 0; i < 4; i++) begin
      put(0, DW'('h40 + i));
      step();
    end
    put(0, DW'('hEE));
    ready_in[0] = 1'b1;
    step();
    idle();
    check("fullrw_cnt7", 0, count_out[0 +: CW], 7);
    check("fullrw_ovf", 0, ovf_err[0], 1);

    // error clear, then set beats clear
    err_clr = 1'b1;
    step();
    idle();
    check("clr_ovf", 0, ovf_err[0], 0);
    put(0, DW'('h50));
    step();
    put(0, DW'('h51));
    err_clr = 1'b1;
    step();
    idle();
    check("set_wins", 0, ovf_err[0], 1);
    flush[0] = 1'b1;
    step();
    idle();

    // write+read on empty port 1
    put(1, DW'('hAA));
    ready_in[1] = 1'b1;
    step();
    idle();
    check("ewr_cnt1", 1, count_out[CW +: CW], 1);
    check("ewr_udf", 1, udf_err[1], 1);
    check("ewr_data", 1, data_out[DW +: DW], 'hAA);

    // flush port 2 with concurrent write
    for (int i = 0; i < 5; i++) begin
      put(2, DW'('h60 + i));
      put(3, DW'('h70 + i));
      step();
    end
    idle();
    flush[2] = 1'b1;
    put(2, DW'('h99));
    step();
    idle();
    check("flush_cnt", 2, count_out[2*CW +: CW], 0);
    check("flush_valid", 2, valid_out[2], 0);
    check("flush_other", 3, count_out[3*CW +: CW], 5);
    err_clr = 1'b1;
    step();
    idle();

    // random traffic with alternating fill/drain bias
    for (int c = 0; c < 400; c++) begin
      int wpct;
      int rpct;
      wpct = ((c / 50) % 2 == 0) ? 75 : 30;
      rpct = ((c / 50) % 2 == 0) ? 30 : 75;
      for (int p = 0; p < NP; p++) begin
        r = {$urandom(), $urandom()};
        data_in[p*DW +: DW] = r[DW-1:0];
        valid_in[p] = ($urandom_range(0, 99) < wpct);
        ready_in[p] = ($urandom_range(0, 99) < rpct);
        flush[p]    = ($urandom_range(0, 99) == 0);
      end
      err_clr = ($urandom_range(0, 19) == 0);
      step();
    end

    // reset mid-traffic with ports partially full
    idle();
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < NP; p++) put(p, DW'('h100 + i));
      step();
    end
    rst      = 1'b1;
    valid_in = '1;
    ready_in = '1;
    step();
    idle();
    check("rst_cnt", 0, count_out, 0);
    check("rst_vld", 0, valid_out, 0);
    check("rst_full", 0, full_out, 0);
    check("rst_afull", 0, afull_out, 0);
    check("rst_data", 0, data_out[63:0], 0);
    check("rst_ovf", 0, ovf_err, 0);
    check("rst_udf", 0, udf_err, 0);

    // writes restart cleanly after reset
    put(4, DW'('h123));
    step();
    put(4, DW'('h124));
    step();
    idle();
    check("post_rst_hd", 4, data_out[4*DW +: DW], 'h123);
    ready_in[4] = 1'b1;
    step();
    idle();
    check("post_rst_nx", 4, data_out[4*DW +: DW], 'h124);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/router_input_buffer.md
# router_input_buffer

Parametrised input-buffer bank for the mesh router: NUM_PORTS independent synchronous FIFOs (N, E, S, W, L, plus any extra ports) share one router clock. Each FIFO is first-word-fall-through. Each also reports its occupancy, almost-full, sticky overflow/underflow errors and a per-port flush. It replaces the fixed five-instance FIFO wrapper for routers where all directions, including Local, run on the router clock.

## Interface
- NUM_PORTS, 5: number of independent FIFO channels; port p occupies bit slice p of every per-port bus.
- DEPTH, 8: entries per FIFO; power of two, ≥ 2.
- DATASIZE, 40: flit width in bits.
- AFULL_THRESH, DEPTH-2: almost-full asserts when count ≥ AFULL_THRESH; legal range 1..DEPTH.
- CW (local), $clog2(DEPTH+1): occupancy counter width.

Ports:
- clk  in  1  router clock; all state on its rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  NUM_PORTS*DATASIZE  write data; port p = [p*DATASIZE +: DATASIZE].
- valid_in  in  NUM_PORTS  write request per port.
- full_out  out  NUM_PORTS  FIFO full (count == DEPTH).
- afull_out  out  NUM_PORTS  count ≥ AFULL_THRESH.
- data_out  out  NUM_PORTS*DATASIZE  head entry; forced to 0 when valid_out[p]=0.
- valid_out  out  NUM_PORTS  FIFO non-empty (count != 0).
- ready_in  in  NUM_PORTS  pop request from the switch allocator.
- count_out  out  NUM_PORTS*CW  current occupancy per port.
- flush  in  NUM_PORTS  synchronous per-port empty command.
- err_clr  in  1  clears all sticky error bits.
- ovf_err  out  NUM_PORTS  sticky: write attempted while full.
- udf_err  out  NUM_PORTS  sticky: pop attempted while empty.

## Operation
- Per port: DEPTH×DATASIZE storage, write pointer, read pointer and count. The pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 → 0.
- Effective write: we = valid_in[p] & ~full_out[p]. Effective read: re = ready_in[p] & valid_out[p].
- Full and empty status comes from the registered count of the current cycle only:
  - A write while full is dropped, even when a read occurs in the same cycle.
  - A read while empty is ignored, even when a write occurs in the same cycle.
- Count update: we&~re → +1; re&~we → −1; both or neither → unchanged.
- The write is stored at wptr, then wptr increments. The read increments rptr. data_out shows mem[rptr] combinationally, masked to 0 when empty.
- Flush: when flush[p]=1, the next state is wptr=rptr=count=0. This overrides any write or read on that port in the same cycle. A flush does not set error bits, and memory contents are not cleared.
- Errors:
  - ovf_err[p] sets when valid_in[p]&full_out[p].
  - udf_err[p] sets when ready_in[p]&~valid_out[p].
  - Set has priority over err_clr in the same cycle.
  - err_clr clears both error vectors.
  - A flush cycle still evaluates error conditions from pre-flush status.
- Ports are fully independent; no activity on one port affects any other port.
- Reset (rst=1 at an edge, at any time, including mid-traffic):
  - All pointers, counts and error bits go to 0.
  - Next cycle outputs: valid_out=0, full_out=0, afull_out=0, count_out=0, data_out=0, ovf_err=0, udf_err=0.
  - Memory is not reset. Inputs are ignored in the reset cycle.

## Timing
- Write to valid: data written at edge k gives valid_out=1 and data_out = that flit after edge k; latency 1 cycle.
- Pop: when re is true at edge k, the next entry (or valid_out=0) is presented after edge k.
- full_out, afull_out and count_out are registered-derived; they update 1 cycle after the causing write, read or flush.
- Sustained throughput: 1 write and 1 read per cycle per port, provided the FIFO is neither full nor empty.
- Full-to-not-full: after a pop from a full FIFO, full_out deasserts at the next edge; writes are accepted again from that cycle.
- No combinational path from valid_in to any output. ready_in reaches only the next state (no combinational output path).

## Test plan
- Fill/drain, DEPTH=8, port 0:
  - Write 0x01..0x08 on consecutive cycles → full_out[0]=1 and count=8 after the 8th edge; afull asserts when count reaches 6.
  - Pop 8 → data_out sequence 0x01..0x08, then valid_out=0 and data_out=0.
- Simultaneous read and write:
  - count=4 with valid_in=ready_in=1 for 20 cycles → count stays 4, order preserved, pointers wrap twice.
  - At full with read and write in the same cycle → write dropped, ovf_err=1, count=7.
- Empty-cycle write+read: valid_in=ready_in=1 on an empty FIFO → pop ignored, udf_err=1, count=1, flit 0xAA presented next cycle.
- Flush: port 2 holds 5 entries; assert flush[2] together with valid_in[2] → count=0, valid_out[2]=0; other ports unchanged.
- Errors and reset:
  - err_clr clears ovf_err and udf_err; a set in the same cycle as err_clr wins.
  - Assert rst with all ports partially full → every output is 0 the next cycle.
  - Writes after reset restart at entry 0.
